load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter addrWidth, default 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have parameter dataWidth, default 32, width of all data buses; only 32 is supported.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  pipeline request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port req_wr  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr  in  addrWidth  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  out  32  extended load result.
REQ-014 SHALL have port rsp_fault  out  1  request rejected; valid with rsp_valid.
REQ-015 SHALL have ports mem_rd out 1, mem_wrt out 1, mem_addr out addrWidth (word index), mem_wdata out 32, mem_rdata in 32: word-wide memory, combinational read, write committed on falling clk edge.

Function
REQ-016 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid&&req_ready, registering all req_* fields.
REQ-018 SHALL leave IDLE on accept: fault -> RESP; load -> RD; word store -> WR; byte/half store -> RD.
REQ-019 SHALL drive in RD: mem_rd=1, mem_wrt=0, mem_addr=addr>>2; capture mem_rdata at the end of the cycle; next state is RESP for a load, WR for a store.
REQ-020 SHALL drive in WR: mem_wrt=1, mem_rd=0, mem_addr=addr>>2, mem_wdata=req_wdata for a word store, or the RD-captured word with the target byte/half lane (addr[1:0]) replaced; next state RESP.
REQ-021 SHALL pulse rsp_valid=1 for exactly one cycle in RESP, then return to IDLE; the response has no backpressure.
REQ-022 SHALL form rsp_rdata for loads by selecting lane addr[1:0] (byte) or addr[1] (half), extending per req_unsigned; stores and faults return 0.
REQ-023 SHALL keep mem_rd=mem_wrt=0, mem_addr=0, mem_wdata=0 in IDLE and RESP.
REQ-024 SHALL give accept-to-rsp_valid latencies: fault 1, load 2, word store 2, sub-word store 3 cycles.
REQ-025 SHALL ignore req_valid outside IDLE; a held request is accepted on the first IDLE edge.
REQ-026 SHALL truncate addresses to addrWidth; no wrap detection.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_rd=mem_wrt=0, mem_addr=mem_wdata=0, with no clock required.
REQ-028 SHALL abort an in-flight request on reset mid-operation: mem_wrt drops immediately so no falling-edge write commits, and no response is produced.

Configuration
REQ-029 SHALL, with LSU_MISALIGN_TRAP_EN defined, fault a request when req_size=11, half with addr[0]=1, or word with addr[1:0]!=0: no memory access, rsp_fault=1.
REQ-030 SHALL, without LSU_MISALIGN_TRAP_EN, never assert rsp_fault, treat size 11 as word, and force misaligned addresses down to size alignment.

Verification
REQ-031 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> mem_wrt one cycle at mem_addr=4; rsp_rdata=0xDEADBEEF two cycles after accept.
REQ-032 Memory word 4 = 0x11223344; byte store 0xAA to 0x12 -> RD then WR, mem_wdata=0x11AA3344, rsp_valid three cycles after accept.
REQ-033 Memory word 4 = 0x0000F080; signed byte load 0x10 -> 0xFFFFFF80; unsigned half load 0x10 -> 0x0000F080; signed half load 0x10 -> 0xFFFFF080.
REQ-034 With LSU_MISALIGN_TRAP_EN, word load 0x11 -> rsp_fault=1, rsp_rdata=0, mem_rd never asserted, latency 1; without it, same access reads word 4.
REQ-035 Assert rst during WR of a store -> mem_wrt low same cycle, memory unchanged, no rsp_valid, req_ready=1 after release.
REQ-036 Hold req_valid for two back-to-back loads -> second accepted only on the first IDLE edge after the first rsp_valid.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles the pipeline request/response handshake and the
//                word-wide memory port of the load/store unit.
//                slave  : the load/store unit itself
//                master : the pipeline plus memory environment around it
//                (drives requests and mem_rdata, observes everything else)
//  Revision    : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  // pipeline request
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [addrWidth-1:0] req_addr;
  logic [dataWidth-1:0] req_wdata;
  // response
  logic                 rsp_valid;
  logic [dataWidth-1:0] rsp_rdata;
  logic                 rsp_fault;
  // memory port
  logic                 mem_rd;
  logic                 mem_wrt;
  logic [addrWidth-1:0] mem_addr;
  logic [dataWidth-1:0] mem_wdata;
  logic [dataWidth-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_rd, mem_wrt, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_rd, mem_wrt, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store unit. Accepts one request in
//                IDLE, performs a read (RD), a write (WR) or a read-modify-
//                write (RD then WR) on a word-wide memory, then pulses a
//                one-cycle response (RESP).
//  Ports       : clk  - clock, all state updates on the rising edge
//                rst  - asynchronous active-high reset
//                bus  - load_store_unit_if.slave: req_* request handshake,
//                       rsp_* completion, mem_* word memory port
//                       (mem_addr is a word index, write commits on the
//                       falling clock edge outside this block)
//  Options     : LSU_MISALIGN_TRAP_EN - when defined, illegal size and
//                misaligned half/word requests fault without touching
//                memory; when undefined they are silently aligned down and
//                size 11 is treated as a word.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_wr;
  logic                 r_uns;
  logic                 r_fault;
  logic [1:0]           r_size;
  logic [addrWidth-1:0] r_addr;
  logic [dataWidth-1:0] r_wdata;
  logic [dataWidth-1:0] r_word;

  logic                 w_accept;
  logic                 w_fault;
  logic [1:0]           w_size_eff;
  logic [addrWidth-1:0] w_addr_eff;
  logic [4:0]           w_sh;
  logic [dataWidth-1:0] w_mask;
  logic [dataWidth-1:0] w_lane;
  logic [dataWidth-1:0] w_load;
  logic [dataWidth-1:0] w_merge;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // Request legalisation: either fault the access or coerce it to a legal,
  // naturally aligned access before it is registered.
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_size_eff = bus.req_size;
    w_addr_eff = bus.req_addr;
    w_fault    = (bus.req_size == 2'b11)
              || ((bus.req_size == 2'b01) && bus.req_addr[0])
              || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    w_fault    = 1'b0;
    w_size_eff = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    w_addr_eff = bus.req_addr;
    case (w_size_eff)
      2'b01:   w_addr_eff = {bus.req_addr[addrWidth-1:1], 1'b0};
      2'b10:   w_addr_eff = {bus.req_addr[addrWidth-1:2], 2'b00};
      default: w_addr_eff = bus.req_addr;
    endcase
  end
`endif

  // Lane helpers: shift amount from the byte offset, and a lane mask sized
  // by the access. Word accesses are aligned, so their shift is always 0.
  assign w_sh = {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_mask = 32'h0000_00FF;
      2'b01:   w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign w_lane  = r_word >> w_sh;
  assign w_merge = (r_word & ~(w_mask << w_sh)) | ((r_wdata & w_mask) << w_sh);

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_lane[7]}},  w_lane[7:0]};
      2'b01:   w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request fields and the word captured at the end of RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_uns   <= 1'b0;
      r_fault <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= bus.req_wr;
        r_uns   <= bus.req_unsigned;
        r_fault <= w_fault;
        r_size  <= w_size_eff;
        r_addr  <= w_addr_eff;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == RD) r_word <= bus.mem_rdata;
    end
  end

  // Next state and outputs. All outputs decode from the state register so
  // that an asynchronous reset clears them (notably mem_wrt) immediately.
  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_fault = 1'b0;
    bus.rsp_rdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wrt   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          if (w_fault)                  w_state_nxt = RESP;
          else if (!bus.req_wr)         w_state_nxt = RD;
          else if (w_size_eff == 2'b10) w_state_nxt = WR;
          else                          w_state_nxt = RD; // read-modify-write
        end
      end
      RD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = r_addr >> 2;
        w_state_nxt  = r_wr ? WR : RESP;
      end
      WR: begin
        bus.mem_wrt   = 1'b1;
        bus.mem_addr  = r_addr >> 2;
        bus.mem_wdata = w_merge;
        w_state_nxt   = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = r_fault;
        bus.rsp_rdata = (!r_wr && !r_fault) ? w_load : '0;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A byte-addressed
//                reference memory predicts load data, store effects, faults
//                and latencies; a word memory model serves the DUT.
//                Honours LSU_MISALIGN_TRAP_EN in its expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b0;
  logic [31:0] seed_base = 32'h0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.addrWidth(32), .dataWidth(32)) bus ();

  load_store_unit #(.addrWidth(32), .dataWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word memory seen by the DUT: 64 words, combinational read, write on the
  // falling edge.
  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];

  function automatic logic [31:0] seed_word(input int i);
    return seed_base ^ (32'(i + 1) * 32'h9E37_79B9);
  endfunction

  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

  always @(negedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
    end else if (bus.mem_wrt) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Reference: byte-level semantics of one request.
  task automatic model(input bit wr, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output bit fault, output logic [31:0] rdata,
                       output int lat, output int nb, output int widx);
    int a;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a  = int'(addr[7:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    fault = (size == 2'd3) || ((a % nb) != 0);
`else
    fault = 1'b0;
    a     = a - (a % nb);
`endif
    widx  = a / 4;
    rdata = 32'h0;
    if (fault) begin
      lat = 1;
    end else if (!wr) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rdata = v;
      lat   = 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[a+i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end
  endtask

  task automatic do_op(input bit wr, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata_o);
    bit efault;
    logic [31:0] erd, wa, wd;
    int elat, eb, widx, lat, nrd, nwr;
    model(wr, size, uns, addr, wdata, efault, erd, elat, eb, widx);
    bus.req_wr       = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; wa = '0; wd = '0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.mem_rd) nrd++;
      if (bus.mem_wrt) begin nwr++; wa = bus.mem_addr; wd = bus.mem_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    rdata_o = bus.rsp_rdata;
    chk("latency", lat, elat);
    chk("rsp_rdata", bus.rsp_rdata, erd);
    chk("rsp_fault", bus.rsp_fault, efault);
    chk("resp_mem_quiet", {bus.mem_rd, bus.mem_wrt}, 2'b00);
    chk("rd_cycles", nrd, (!efault && (!wr || eb < 4)) ? 1 : 0);
    chk("wr_cycles", nwr, (!efault && wr) ? 1 : 0);
    if (!efault && wr) begin
      chk("wr_addr", wa, widx);
      chk("wr_data", wd, ref_word(widx));
      chk("mem_after_store", mem[widx], ref_word(widx));
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", bus.rsp_valid, 1'b0);
    chk("ready_after", bus.req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] rd, saved, erd;
    bit ef;
    int el, eb, wi, cyc, first, second;

    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    seed_base = $urandom;
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = seed_word(i)[8*b +: 8];

    // Reset values before any clock edge
    #2;
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_fault", bus.rsp_fault, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_ctl", {bus.mem_rd, bus.mem_wrt}, 2'b00);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    mem_load = 1'b1;
    repeat (2) @(posedge clk);
    #1; mem_load = 1'b0; rst = 1'b0;

    // Word store then word load
    do_op(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, rd);
    do_op(0, 2'b10, 0, 32'h10, 32'h0, rd);
    chk("word_load_const", rd, 32'hDEAD_BEEF);

    // Byte store read-modify-write
    do_op(1, 2'b10, 0, 32'h10, 32'h1122_3344, rd);
    do_op(1, 2'b00, 0, 32'h12, 32'h0000_00AA, rd);
    chk("byte_store_const", mem[4], 32'h11AA_3344);

    // Extension rules
    do_op(1, 2'b10, 0, 32'h10, 32'h0000_F080, rd);
    do_op(0, 2'b00, 0, 32'h10, 32'h0, rd);
    chk("ld_sbyte_const", rd, 32'hFFFF_FF80);
    do_op(0, 2'b01, 1, 32'h10, 32'h0, rd);
    chk("ld_uhalf_const", rd, 32'h0000_F080);
    do_op(0, 2'b01, 0, 32'h10, 32'h0, rd);
    chk("ld_shalf_const", rd, 32'hFFFF_F080);

    // Misaligned word and illegal size
    do_op(0, 2'b10, 0, 32'h11, 32'h0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misalign_word_const", rd, 32'h0);
`else
    chk("misalign_word_const", rd, 32'h0000_F080);
`endif
    do_op(0, 2'b11, 0, 32'h10, 32'h0, rd);
    do_op(1, 2'b01, 0, 32'h23, 32'h0000_BEEF, rd);

    // Reset while a sub-word store is in WR
    bus.req_wr = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h0000_005A; bus.req_valid = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_wrt", bus.mem_wrt, 1'b1);
    saved = mem[8];
    rst = 1'b1; #1;
    chk("rst_async_wrt", bus.mem_wrt, 1'b0);
    chk("rst_async_ready", bus.req_ready, 1'b1);
    @(negedge clk); #1;
    chk("rst_no_commit", mem[8], saved);
    chk("rst_mem_model", mem[8], ref_word(8));
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", bus.rsp_valid, 1'b0);
      chk("rst_idle_ready", bus.req_ready, 1'b1);
    end

    // Held request: back-to-back loads
    model(0, 2'b10, 0, 32'h40, 32'h0, ef, erd, el, eb, wi);
    bus.req_wr = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1; first = 0; second = 0;
    while (second == 0 && cyc < 12) begin
      if (bus.rsp_valid) begin
        chk("b2b_rdata", bus.rsp_rdata, erd);
        if (first == 0) first = cyc;
        else begin second = cyc; bus.req_valid = 1'b0; end
      end
      if (second == 0) begin @(posedge clk); #1; cyc++; end
    end
    chk("b2b_first", first, 2);
    chk("b2b_second", second, 5);
    @(posedge clk); #1;
    chk("b2b_idle", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    chk("b2b_no_third", bus.req_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 150; i++)
      do_op(1'($urandom), 2'($urandom), 1'($urandom), {24'h0, 8'($urandom)},
            $urandom, rd);

    // Final memory consistency
    for (int i = 0; i < 64; i += 9) chk("mem_final", mem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
